// File: rtl/lab5cpu_parallel_input.sv
// Avalon-MM parallel input port: two-flop synchronizer on the external bus,
// sticky per-bit rising-edge capture (write-1-to-clear), and a maskable
// level interrupt. Reads are zero-latency and gated by chipselect.
module lab5cpu_parallel_input #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] cap_q,   cap_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    // Only the low WIDTH bits of writedata reach any register.
    if (WIDTH < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[31:WIDTH];
    end

    // Next-state: synchronizer shift, edge detect, sticky capture with set-over-clear, mask load.
    always_comb begin
        wr_en   = chipselect & ~write_n;
        rise    = sync2_q & ~prev_q;
        clr     = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cap_d   = (cap_q & ~clr) | rise;
        mask_d  = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
    end

    // State registers; reset clears everything immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
        end
    end

    // Zero-latency read mux, zero-extended and forced to 0 when not selected.
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata[WIDTH-1:0] = sync2_q;
                ADDR_DIR:     readdata = '0;
                ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
                ADDR_EDGECAP: readdata[WIDTH-1:0] = cap_q;
                default:      readdata = '0;
            endcase
        end
    end

    // Level interrupt straight from the capture and mask registers.
    assign irq = |(cap_q & mask_q);

endmodule
